// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings, default width, counter sizing.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter must hold 0..WIDTH-1; never narrower than one bit.
  function automatic int cnt_bits(input int width);
    return (width < 2) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle of the serial adder; Ovf_o exists only with SERIAL_ADDER_OVF_EN.
interface serial_adder_ctrl_if
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             Start_i;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             C_i;
  logic             Busy_o;
  logic             Done_o;
  logic [WIDTH-1:0] S_o;
  logic             C_o;

`ifdef SERIAL_ADDER_OVF_EN
  logic             Ovf_o;

  modport master (output Start_i, A_i, B_i, C_i,
                  input  Busy_o, Done_o, S_o, C_o, Ovf_o);
  modport slave  (input  Start_i, A_i, B_i, C_i,
                  output Busy_o, Done_o, S_o, C_o, Ovf_o);
`else
  modport master (output Start_i, A_i, B_i, C_i,
                  input  Busy_o, Done_o, S_o, C_o);
  modport slave  (input  Start_i, A_i, B_i, C_i,
                  output Busy_o, Done_o, S_o, C_o);
`endif

endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell, purely combinational (zero latency, no flow control).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell, LSB first; Done_o WIDTH cycles after accept, Start_i ignored while busy.
// Optional signed-overflow output under SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               Clk_i,
  input  logic               Rst_ni,
  serial_adder_ctrl_if.slave bus
);

  localparam int            CW   = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_nxt;
  logic [WIDTH-1:0] s_q;
  logic             cy_q;
  logic             c_q;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (cy_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign s_nxt    = (s_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  assign last_bit = (state == ST_RUN) && (cnt == LAST);

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      cy_q  <= 1'b0;
      s_q   <= '0;
      c_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.Start_i) begin
            a_sh  <= bus.A_i;
            b_sh  <= bus.B_i;
            cy_q  <= bus.C_i;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          s_sh <= s_nxt;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cy_q <= fa_co;
          cnt  <= cnt + 1'b1;
          if (last_bit) begin
            s_q   <= s_nxt;
            c_q   <= fa_co;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // Carry into the MSB is cy_q during the last bit; carry out is fa_co.
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      ovf_q <= 1'b0;
    end else if (last_bit) begin
      ovf_q <= cy_q ^ fa_co;
    end
  end

  assign bus.Ovf_o = ovf_q;
`endif

  assign bus.Busy_o = (state != ST_IDLE);
  assign bus.Done_o = (state == ST_DONE);
  assign bus.S_o    = s_q;
  assign bus.C_o    = c_q;

endmodule
